// File: rtl/step_edge_counter.sv
// Pedometer step counter: sync, debounce, edge qualify,
// saturating total count and per-window cadence rate.
module step_edge_counter #(
  parameter int WIDTH           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 0,
  parameter int WINDOW_CYCLES   = 100000000,
  parameter int RATE_WIDTH      = 8
) (
  input  logic                  clk100MHz,
  input  logic                  reset,
  input  logic                  X,
  input  logic                  clear,
  output logic [WIDTH-1:0]      step_count,
  output logic                  step_pulse,
  output logic                  saturated,
  output logic [RATE_WIDTH-1:0] rate,
  output logic                  rate_valid
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(WINDOW_CYCLES - 1);

  localparam logic [WIDTH-1:0]      CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [RATE_WIDTH-1:0] RATE_MAX = {RATE_WIDTH{1'b1}};

  // Mode 3 is illegal and falls back to rising-edge only.
  localparam bit USE_RISE = (EDGE_MODE != 1);
  localparam bit USE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  logic            s1;
  logic            s2;
  logic            x_db;
  logic            x_db_d;
  logic [DB_W-1:0] db_cnt;

  logic rise;
  logic fall;
  logic step;

  logic [WIN_W-1:0]      win_cnt;
  logic [RATE_WIDTH-1:0] acc;
  logic [RATE_WIDTH-1:0] acc_next;
  logic                  wrap;

  // Two-flop synchroniser for the asynchronous sensor line.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= X;
      s2 <= s1;
    end
  end

  // Accept a new level only after it persists DEBOUNCE_CYCLES.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      x_db   <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == x_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      x_db   <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // One-cycle delayed copy of the debounced level.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      x_db_d <= 1'b0;
    end else begin
      x_db_d <= x_db;
    end
  end

  // Edge detect and mode selection.
  always_comb begin
    rise = x_db & ~x_db_d;
    fall = ~x_db & x_db_d;
    step = (USE_RISE & rise) | (USE_FALL & fall);
  end

  // Saturating total; clear beats a same-cycle step.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      step_count <= '0;
      saturated  <= 1'b0;
    end else if (clear) begin
      step_count <= '0;
      saturated  <= 1'b0;
    end else if (step) begin
      if (step_count != CNT_MAX) begin
        step_count <= step_count + WIDTH'(1);
      end else begin
        saturated <= 1'b1;
      end
    end
  end

  // Registered step strobe, independent of saturation.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step;
    end
  end

  // Window accumulator including this cycle's step.
  always_comb begin
    wrap     = (win_cnt == WIN_LAST);
    acc_next = acc;
    if (step && (acc != RATE_MAX)) begin
      acc_next = acc + RATE_WIDTH'(1);
    end
  end

  // Window timer, accumulator and rate publication.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else if (wrap) begin
      win_cnt    <= '0;
      acc        <= '0;
      rate       <= acc_next;
      rate_valid <= 1'b1;
    end else begin
      win_cnt    <= win_cnt + WIN_W'(1);
      acc        <= acc_next;
      rate_valid <= 1'b0;
    end
  end

endmodule
